// File: rtl/seq_multiplier_pkg.sv
// Shared types for the sequential multiplier.
//   func_t  : register select on the shared data bus
//   state_t : control FSM states
package mult_pkg;

    localparam int FUNC_W = 2;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_A   = 2'b00,
        FUNC_B   = 2'b01,
        FUNC_PLO = 2'b10,
        FUNC_PHI = 2'b11
    } func_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Control handshake of the sequential multiplier.
//   start, load, oe, func, signed_mode : host -> multiplier
//   ready                              : multiplier -> host
// The shared tri-state data bus stays a plain inout on the block.
interface seq_multiplier_if;
    import mult_pkg::*;

    logic  start;
    logic  load;
    logic  oe;
    func_t func;
    logic  signed_mode;
    logic  ready;

    modport master (output start, load, oe, func, signed_mode, input ready);
    modport slave  (input start, load, oe, func, signed_mode, output ready);

endinterface

// File: rtl/seq_multiplier_shift_add_core.sv
// Iterative shift-add engine for unsigned N x N -> 2N products.
//   clock, reset : system clock, synchronous active-high reset
//   init         : load operands, clear accumulator and count
//   step         : one shift-add iteration
//   mcand, mplier: unsigned magnitude operands
//   acc          : running/final 2N-bit product
//   last         : high during the final (N-th) iteration
module shift_add_core #(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           init,
    input  logic           step,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic [2*N-1:0] acc,
    output logic           last
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] mcand_sh;
    logic [N-1:0]   mplier_sh;
    logic [CW-1:0]  count;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            count     <= '0;
        end else if (init) begin
            acc       <= '0;
            mcand_sh  <= {{N{1'b0}}, mcand};
            mplier_sh <= mplier;
            count     <= '0;
        end else if (step) begin
            if (mplier_sh[0])
                acc <= acc + mcand_sh;
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            count     <= count + 1'b1;
        end
    end

    assign last = (count == CW'(N - 1));

endmodule

// File: rtl/seq_multiplier.sv
// Bus-attached sequential multiplier, unsigned or two's-complement.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : start/load/oe/func/signed_mode in, ready out
//   data         : shared N-bit tri-state bus (operand writes, register reads)
// Signed products are formed from operand magnitudes and negated at the end,
// so the core only ever does unsigned arithmetic.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clock,
    input  logic             reset,
    seq_multiplier_if.slave  bus,
    inout  wire  [N-1:0]     data
);
    state_t         state;
    logic [N-1:0]   a, b;
    logic [2*N-1:0] p;
    logic           sign;
    logic           ready_q;

    logic [N-1:0]   mag_a, mag_b;
    logic [2*N-1:0] acc;
    logic           last;
    logic           init, step;
    logic [N-1:0]   rdata;

    // -2^(N-1) negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = (bus.signed_mode && a[N-1]) ? -a : a;
        mag_b = (bus.signed_mode && b[N-1]) ? -b : b;
    end

    assign init = (state == IDLE) && bus.start;
    assign step = (state == RUN);

    shift_add_core #(.N(N)) u_core (
        .clock  (clock),
        .reset  (reset),
        .init   (init),
        .step   (step),
        .mcand  (mag_a),
        .mplier (mag_b),
        .acc    (acc),
        .last   (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            a       <= '0;
            b       <= '0;
            p       <= '0;
            sign    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // start beats a same-edge load so the op uses the old A/B
                    if (bus.start) begin
                        sign    <= bus.signed_mode & (a[N-1] ^ b[N-1]);
                        state   <= RUN;
                        ready_q <= 1'b0;
                    end else if (bus.load) begin
                        case (bus.func)
                            FUNC_A:  a <= data;
                            FUNC_B:  b <= data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (last)
                        state <= FIX;
                end
                FIX: begin
                    p       <= sign ? -acc : acc;
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;

    always_comb begin
        case (bus.func)
            FUNC_A:   rdata = a;
            FUNC_B:   rdata = b;
            FUNC_PLO: rdata = p[N-1:0];
            FUNC_PHI: rdata = p[2*N-1:N];
            default:  rdata = '0;
        endcase
    end

    // load claims the bus for the host, so never drive while it is high
    assign data = (bus.oe && !bus.load) ? rdata : {N{1'bz}};

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
    import mult_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_multiplier_if bus();
    wire  [7:0] data;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = 8'h00;
    assign data = tb_drv ? tb_val : 8'bz;

    seq_multiplier #(.N(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_p = 16'h0;
    logic [15:0] mon_exp;
    logic [7:0]  mon_lo;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer product of the operands as interpreted by the mode.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int ia, ib, prod;
        ia   = sm ? int'($signed(a)) : int'(a);
        ib   = sm ? int'($signed(b)) : int'(b);
        prod = ia * ib;
        return 16'(prod);
    endfunction

    // Monitor: a PLO read followed by a PHI read completes one observed product.
    always @(negedge clock) begin
        if (chk_en && bus.oe && !bus.load) begin
            if (bus.func == FUNC_PLO) begin
                mon_lo = data;
            end else if (bus.func == FUNC_PHI) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("product", {16'h0, data, mon_lo}, {16'h0, mon_exp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input func_t f, input logic [7:0] v);
        bus.func = f; bus.load = 1'b1; tb_drv = 1'b1; tb_val = v;
        tick();
        bus.load = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic rd(input func_t f, output logic [7:0] v);
        bus.oe = 1'b1; bus.func = f;
        @(negedge clock);
        v = data;
        tick();
        bus.oe = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_result(input logic [15:0] exp);
        logic [7:0] v;
        chk_en = 1'b1;
        rd(FUNC_PLO, v);
        rd(FUNC_PHI, v);
        chk_en = 1'b0;
        last_p = exp;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [15:0] exp);
        int n;
        wr(FUNC_A, a);
        wr(FUNC_B, b);
        exp_q.push_back(exp);
        bus.signed_mode = sm; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.signed_mode = ~sm;  // must be ignored after the start edge
        wait_ready(n);
        check("ready_low_cycles", n, 32'd9);
        read_result(exp);
    endtask

    initial begin
        logic [7:0] v, ra, rb;
        logic       rs;
        int         n;

        bus.start = 1'b0; bus.load = 1'b0; bus.oe = 1'b0;
        bus.func = FUNC_A; bus.signed_mode = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // reset state
        check("reset_ready", bus.ready, 32'd1);
        rd(FUNC_A, v);   check("reset_a", v, 32'h00);
        rd(FUNC_B, v);   check("reset_b", v, 32'h00);
        rd(FUNC_PLO, v); check("reset_plo", v, 32'h00);
        rd(FUNC_PHI, v); check("reset_phi", v, 32'h00);

        // unsigned basic
        run_op(8'd123, 8'd234, 1'b0, 16'h706E);

        // bus release: oe=0, then oe+load together (load with PLO select is ignored)
        bus.func = FUNC_A; bus.oe = 1'b0;
        @(negedge clock);
        check("no_drive_oe0", {31'h0, data === 8'h7B}, 32'd0);
        tick();
        bus.func = FUNC_PLO; bus.oe = 1'b1; bus.load = 1'b1;
        @(negedge clock);
        check("no_drive_oe_load", {31'h0, data === 8'h6E}, 32'd0);
        tick();
        bus.oe = 1'b0; bus.load = 1'b0;
        rd(FUNC_PLO, v); check("plo_after_ignored_load", v, 32'h6E);

        // signed / unsigned pairs and corners
        run_op(8'h55, 8'hAA, 1'b1, 16'hE372);
        run_op(8'h55, 8'hAA, 1'b0, 16'h3872);
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op(8'h80, 8'h80, 1'b1, 16'h4000);
        run_op(8'h80, 8'h01, 1'b1, 16'hFF80);
        run_op(8'hC3, 8'h00, 1'b1, 16'h0000);
        run_op(8'h00, 8'h9D, 1'b0, 16'h0000);

        // randomized against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs));
        end

        // busy: loads, start and reads during RUN
        wr(FUNC_A, 8'h55);
        wr(FUNC_B, 8'h03);
        exp_q.push_back(16'h00FF);
        bus.signed_mode = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        wr(FUNC_A, 8'h11);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rd(FUNC_PLO, v); check("busy_read_old_p", v, {24'h0, last_p[7:0]});
        wait_ready(n);
        read_result(16'h00FF);
        tick(); tick();
        check("no_second_op", bus.ready, 32'd1);
        rd(FUNC_A, v); check("busy_load_ignored", v, 32'h55);

        // same-edge start + load: the op uses the pre-edge A
        wr(FUNC_A, 8'd5);
        wr(FUNC_B, 8'd7);
        exp_q.push_back(16'd35);
        bus.start = 1'b1; bus.load = 1'b1; bus.func = FUNC_A; tb_drv = 1'b1; tb_val = 8'd9;
        tick();
        bus.start = 1'b0; bus.load = 1'b0; tb_drv = 1'b0;
        wait_ready(n);
        check("same_edge_latency", n, 32'd9);
        read_result(16'd35);
        rd(FUNC_A, v); check("same_edge_a_kept", v, 32'd5);

        // reset during RUN aborts and clears everything
        wr(FUNC_A, 8'h12);
        wr(FUNC_B, 8'h34);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", bus.ready, 32'd1);
        rd(FUNC_PLO, v); check("abort_plo", v, 32'h00);
        rd(FUNC_PHI, v); check("abort_phi", v, 32'h00);
        rd(FUNC_A, v);   check("abort_a", v, 32'h00);

        // a fresh op after the abort still works
        run_op(8'hF6, 8'h0B, 1'b1, 16'hFF92);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised, clocked successor to the bus-attached `multiplier`. It computes N×N→2N products by iterative shift-add, in either unsigned or two's-complement signed mode. Operands are written and results read over a shared bidirectional N-bit `data` bus. The `func`/`oe`/`start`/`ready` handshake is kept, and a dedicated write strobe is added. The block sits on the lab datapath bus alongside other tri-state peripherals.

## Interface
Parameters:
- `N`, 8, operand width in bits; product is 2N bits; N ≥ 2.

Ports:
- `clock`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on rising edge of `clock`.
- `start`  in  1  launch request; honoured only when `ready`=1.
- `load`  in  1  write strobe; captures `data` into the operand selected by `func`.
- `oe`  in  1  output enable; drives the register selected by `func` onto `data`.
- `func`  in  2  register select: 00 operand A, 01 operand B, 10 product low, 11 product high.
- `signed_mode`  in  1  1 = two's-complement operands/product; sampled with `start`.
- `data`  inout  N  shared bus; high-Z unless driving.
- `ready`  out  1  1 = idle, product register valid, new start accepted.

## Operation
- Registers: A[N], B[N], P[2N] (visible product), working accumulator, multiplier shift register, count, sign flag, state.
- Reset: A=0, B=0, P=0, `ready`=1, state IDLE, `data`=Z. Reset mid-computation aborts; P returns to 0.
- Write: `load`=1 with func 00/01 captures `data` into A/B at the edge.
  - func 10/11 with `load` is ignored.
  - Loads are ignored while `ready`=0.
- Read: `oe`=1 and `load`=0 drive A, B, P[N-1:0] or P[2N-1:N] per `func`, combinationally.
  - `load`=1 forces Z, so there is no bus contention.
  - Reads are allowed while busy and return the previous product.
- States:
  - IDLE: `start`=1 goes to RUN. It latches |A| and |B| (magnitudes if signed_mode, else raw), sign = A[N-1]^B[N-1] & signed_mode, and clears the accumulator and count.
  - RUN: each cycle, if multiplier LSB is 1, add the multiplicand (shifted) into the accumulator. Shift; count++. After N cycles go to FIX.
  - FIX: P ← sign ? −acc : acc (2N-bit two's complement). Go to IDLE.
- `start` and `load` on the same edge in IDLE: start wins, load is ignored, and the operation uses the pre-edge A/B.
- `start` while `ready`=0 is ignored; it is not queued.
- Width rules:
  - The magnitude of the most negative value (−2^(N−1)) fits in N unsigned bits.
  - Signed products always fit in 2N bits.
  - Unsigned products never overflow.

## Timing
- `start` sampled high at edge k (IDLE): `ready`=0 from after edge k, through RUN (N cycles) and FIX (1 cycle).
- P updated and `ready`=1 after edge k+N+1. Latency is N+1 cycles; throughput is one product per N+2 cycles minimum, since a new `start` can be sampled at edge k+N+2.
- `ready` is registered (state==IDLE); no combinational path from inputs to `ready`.
- `data` output path is combinational from `oe`/`load`/`func` and registers.
- `signed_mode` is ignored except at the start edge.

## Structure
- Package `mult_pkg`:
  - `func_t` enum: FUNC_A, FUNC_B, FUNC_PLO, FUNC_PHI.
  - `state_t` enum: IDLE, RUN, FIX.
- Sub-module `shift_add_core #(N)`: accumulator, multiplier shift register and counter. Inputs: init, step, magnitude operands. Outputs: acc[2N], last.
- Top holds the bus interface, the operand/product registers, the FSM and sign fix-up.
- Expected size: ~150–250 lines total.

## Test plan
(N=8 throughout.)
1. Unsigned: load A=123, B=234, start, wait `ready`. Expect:
   - func 10 reads 0x6E; func 11 reads 0x70.
   - `ready` low for exactly 9 cycles.
2. Signed: A=0x55, B=0xAA, signed_mode=1. Expect P=0xE372 (85×−86=−7310).
   - Same operands unsigned give 0x3872.
3. Corners:
   - Unsigned 0xFF×0xFF gives 0xFE01.
   - Signed 0x80×0x80 gives 0x4000.
   - Signed 0x80×0x01 gives 0xFF80.
   - Any ×0 gives 0x0000.
4. Busy behaviour, with A=0x55 loaded: during RUN, load A=0x11, assert `start` again, and read func 10. Expect:
   - A stays 0x55.
   - No second operation is started.
   - The read returns the old P.
5. Reset at RUN cycle 3. Expect, next cycle:
   - `ready`=1 and P=0.
   - A reads 0x00 and `data` is Z with `oe`=0.
6. Bus: `oe`=1 and `load`=1 together leave `data` undriven by the block. Same-edge `start`+`load` uses the old A.
